// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: state encoding, BCD widths and digit limits.
// The ADJUST state only exists when STOPWATCH_ADJUST_EN is defined.
package stopwatch_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

`ifdef STOPWATCH_ADJUST_EN
    typedef enum logic [1:0] {
        ST_CLEARED,
        ST_RUN,
        ST_PAUSED,
        ST_ADJUST
    } sw_state_e;
`else
    typedef enum logic [1:0] {
        ST_CLEARED,
        ST_RUN,
        ST_PAUSED
    } sw_state_e;
`endif

    // Two-digit BCD image of a small integer, used for the minute wrap compare.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One registered BCD digit counting 0..TOP; carry is combinational and flags an increment at TOP.
// clr wins over inc; the new value appears one clock after inc/clr is sampled.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int TOP = DIGIT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] value,
    output logic             carry
);

    localparam logic [BCD_W-1:0] TOP_V = BCD_W'(TOP);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W-1:0] value_d;

    assign carry = inc && (value_q == TOP_V);

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (carry) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause/clear control; digits, RUNNING and WRAP update one clock after the request.
// Optional field-adjust mode in PAUSED is compiled in with STOPWATCH_ADJUST_EN.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic             CLK_REF,
    input  logic             CLK_RES_N,
    input  logic             TICK_1HZ,
    input  logic             TICK_2HZ,
    input  logic             BTN_PAUSE,
    input  logic             BTN_CLEAR,
    input  logic             ADJ,
    input  logic             SEL,
    output logic [BCD_W-1:0] MIN_TENS,
    output logic [BCD_W-1:0] MIN_ONES,
    output logic [BCD_W-1:0] SEC_TENS,
    output logic [BCD_W-1:0] SEC_ONES,
    output logic             RUNNING,
    output logic             WRAP
);

    localparam int                   MIN_TENS_TOP = MIN_MAX / 10;
    localparam logic [2*BCD_W-1:0]   MIN_MAX_BCD  = to_bcd2(MIN_MAX);

    // Reset asserts immediately but releases only after two clean edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
        if (!CLK_RES_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    sw_state_e state_q;
    sw_state_e state_d;
    logic      running_q;
    logic      wrap_q;
    logic      wrap_d;

    logic run_tick;
    logic adj_tick;
    logic adj_sel_min;
    logic sec_inc;
    logic min_inc;
    logic min_at_max;
    logic min_wrap;
    logic so_carry;
    logic st_carry;
    logic mo_carry;
    logic unused_mt_carry;

    assign run_tick = (state_q == ST_RUN) && TICK_1HZ && !BTN_CLEAR;

`ifdef STOPWATCH_ADJUST_EN
    assign adj_tick    = (state_q == ST_ADJUST) && TICK_2HZ && !BTN_CLEAR;
    assign adj_sel_min = SEL;
`else
    logic unused_adj;
    assign unused_adj  = ^{ADJ, SEL, TICK_2HZ};
    assign adj_tick    = 1'b0;
    assign adj_sel_min = 1'b0;
`endif

    // Adjust steps one field only, so the seconds carry never reaches minutes there.
    assign sec_inc    = run_tick || (adj_tick && !adj_sel_min);
    assign min_inc    = (run_tick && st_carry) || (adj_tick && adj_sel_min);
    assign min_at_max = ({MIN_TENS, MIN_ONES} == MIN_MAX_BCD);
    assign min_wrap   = min_inc && min_at_max;
    assign wrap_d     = run_tick && st_carry && min_at_max;

    always_comb begin
        state_d = state_q;
        if (BTN_CLEAR) begin
            state_d = ST_CLEARED;
        end else begin
            case (state_q)
                ST_CLEARED: if (BTN_PAUSE) state_d = ST_RUN;
                ST_RUN:     if (BTN_PAUSE) state_d = ST_PAUSED;
`ifdef STOPWATCH_ADJUST_EN
                ST_PAUSED: begin
                    if (BTN_PAUSE) begin
                        state_d = ST_RUN;
                    end else if (ADJ) begin
                        state_d = ST_ADJUST;
                    end
                end
                ST_ADJUST:  if (!ADJ) state_d = ST_PAUSED;
`else
                ST_PAUSED:  if (BTN_PAUSE) state_d = ST_RUN;
`endif
                default:    state_d = ST_CLEARED;
            endcase
        end
    end

    always_ff @(posedge CLK_REF or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEARED;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            wrap_q    <= wrap_d;
        end
    end

    assign RUNNING = running_q;
    assign WRAP    = wrap_q;

    bcd_digit #(.TOP(DIGIT_MAX)) u_sec_ones (
        .clk   (CLK_REF),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (BTN_CLEAR),
        .value (SEC_ONES),
        .carry (so_carry)
    );

    bcd_digit #(.TOP(SEC_TENS_MAX)) u_sec_tens (
        .clk   (CLK_REF),
        .rst_n (rst_n),
        .inc   (so_carry),
        .clr   (BTN_CLEAR),
        .value (SEC_TENS),
        .carry (st_carry)
    );

    // Minute wrap is decided on the combined value, so MIN_MAX need not end in 9.
    bcd_digit #(.TOP(DIGIT_MAX)) u_min_ones (
        .clk   (CLK_REF),
        .rst_n (rst_n),
        .inc   (min_inc && !min_wrap),
        .clr   (BTN_CLEAR || min_wrap),
        .value (MIN_ONES),
        .carry (mo_carry)
    );

    bcd_digit #(.TOP(MIN_TENS_TOP)) u_min_tens (
        .clk   (CLK_REF),
        .rst_n (rst_n),
        .inc   (mo_carry),
        .clr   (BTN_CLEAR || min_wrap),
        .value (MIN_TENS),
        .carry (unused_mt_carry)
    );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: a seconds-based reference model queues expected outputs per cycle.
module tb_stopwatch_counter;

    localparam int MIN_MAX   = 59;
    localparam int WRAP_SECS = 60 * (MIN_MAX + 1);
`ifdef STOPWATCH_ADJUST_EN
    localparam bit ADJ_EN = 1'b1;
`else
    localparam bit ADJ_EN = 1'b0;
`endif

    logic       CLK_REF = 1'b0;
    logic       CLK_RES_N = 1'b0;
    logic       TICK_1HZ = 1'b0;
    logic       TICK_2HZ = 1'b0;
    logic       BTN_PAUSE = 1'b0;
    logic       BTN_CLEAR = 1'b0;
    logic       ADJ = 1'b0;
    logic       SEL = 1'b0;
    logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
    logic       RUNNING, WRAP;

    typedef struct packed {
        logic [15:0] digits;
        logic        running;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_secs  = 0;
    int   m_state = 0;   // 0 cleared, 1 run, 2 paused, 3 adjust
    logic m_wrap  = 1'b0;

    stopwatch_counter #(.MIN_MAX(MIN_MAX)) dut (
        .CLK_REF   (CLK_REF),
        .CLK_RES_N (CLK_RES_N),
        .TICK_1HZ  (TICK_1HZ),
        .TICK_2HZ  (TICK_2HZ),
        .BTN_PAUSE (BTN_PAUSE),
        .BTN_CLEAR (BTN_CLEAR),
        .ADJ       (ADJ),
        .SEL       (SEL),
        .MIN_TENS  (MIN_TENS),
        .MIN_ONES  (MIN_ONES),
        .SEC_TENS  (SEC_TENS),
        .SEC_ONES  (SEC_ONES),
        .RUNNING   (RUNNING),
        .WRAP      (WRAP)
    );

    always #5 CLK_REF = ~CLK_REF;

    function automatic logic [15:0] to_digits(input int s);
        int m;
        int x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic exp_t dut_obs();
        return '{{MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES}, RUNNING, WRAP};
    endfunction

    // Drives one clock of stimulus from a falling edge, advances the model and queues the expectation.
    task automatic drive_cycle(input logic t1, input logic p = 1'b0, input logic c = 1'b0,
                               input logic a = 1'b0, input logic s = 1'b0, input logic t2 = 1'b0);
        TICK_1HZ = t1; BTN_PAUSE = p; BTN_CLEAR = c; ADJ = a; SEL = s; TICK_2HZ = t2;
        m_wrap = 1'b0;
        if (c) begin
            m_secs = 0;
            m_state = 0;
        end else begin
            case (m_state)
                0: if (p) m_state = 1;
                1: begin
                    if (t1) begin
                        m_secs = (m_secs + 1) % WRAP_SECS;
                        m_wrap = (m_secs == 0);
                    end
                    if (p) m_state = 2;
                end
                2: begin
                    if (p) m_state = 1;
                    else if (a && ADJ_EN) m_state = 3;
                end
                default: begin
                    if (t2) begin
                        if (s) m_secs = ((m_secs / 60 + 1) % (MIN_MAX + 1)) * 60 + m_secs % 60;
                        else   m_secs = (m_secs / 60) * 60 + (m_secs % 60 + 1) % 60;
                    end
                    if (!a) m_state = 2;
                end
            endcase
        end
        sb.push_back('{to_digits(m_secs), (m_state == 1), m_wrap});
        @(posedge CLK_REF);
        @(negedge CLK_REF);
        TICK_1HZ = 1'b0; BTN_PAUSE = 1'b0; BTN_CLEAR = 1'b0; TICK_2HZ = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, got;
        CLK_RES_N = 1'b0;
        repeat (3) @(negedge CLK_REF);
        m_secs = 0; m_state = 0;
        sb.push_back('{16'h0000, 1'b0, 1'b0});
        e = sb.pop_front(); got = dut_obs(); n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_hold: got %h run=%b wrap=%b, want %h run=%b wrap=%b", got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
        end
        CLK_RES_N = 1'b1;
        repeat (3) @(negedge CLK_REF);
        drive_cycle(1'b1);
        e = sb.pop_front(); got = dut_obs(); n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_tick_ignored: got %h run=%b wrap=%b, want %h run=%b wrap=%b", got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
        end
    endtask

    task automatic test_count();
        exp_t e, got;
        for (int i = 0; i < 82; i++) begin
            if (i == 0)       drive_cycle(1'b0, 1'b1);
            else if (i <= 61) drive_cycle(1'b1);
            else              drive_cycle(1'($urandom_range(0, 1)));
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL count[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
            if (i == 61) begin
                n_tests++;
                if ({got.digits, got.running} !== {16'h0101, 1'b1}) begin
                    n_fail++;
                    $display("FAIL count_61: got %h run=%b, want 0101 run=1", got.digits, got.running);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e, got;
        for (int i = 0; i < 3604; i++) begin
            if (i == 0)        drive_cycle(1'b0, 1'b0, 1'b1);
            else if (i == 1)   drive_cycle(1'b0, 1'b1);
            else if (i < 3602) drive_cycle(1'b1);
            else               drive_cycle(i == 3602);
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
        end
    endtask

    task automatic test_tick_pause();
        exp_t e, got;
        for (int i = 0; i < 21; i++) begin
            case (i)
                0:       drive_cycle(1'b0, 1'b0, 1'b1);
                1:       drive_cycle(1'b0, 1'b1);
                7:       drive_cycle(1'b1, 1'b1);
                18:      drive_cycle(1'b1, 1'b1);
                default: drive_cycle(1'b1);
            endcase
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL tick_pause[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
        end
    endtask

    task automatic test_clear_priority();
        exp_t e, got;
        for (int i = 0; i < 759; i++) begin
            if (i == 0)       drive_cycle(1'b0, 1'b0, 1'b1);
            else if (i == 1)  drive_cycle(1'b0, 1'b1);
            else if (i < 756) drive_cycle(1'b1);
            else if (i == 756) drive_cycle(1'b1, 1'b1, 1'b1);
            else if (i == 757) drive_cycle(1'b1);
            else              drive_cycle(1'b1, 1'b1);
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL clear_prio[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
        end
    endtask

    task automatic test_adjust();
        exp_t e, got;
        for (int i = 0; i < 70; i++) begin
            case (i)
                0:          drive_cycle(1'b0, 1'b0, 1'b1);
                1:          drive_cycle(1'b0, 1'b1);
                60:         drive_cycle(1'b0, 1'b1);
                61:         drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                62, 64:     drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
                63:         drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
                65, 66:     drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                67:         drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                68:         drive_cycle(1'b0, 1'b1);
                69:         drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                default:    drive_cycle(1'b1);
            endcase
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL adjust[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, got;
        for (int i = 0; i < 429; i++) begin
            if (i == 0)      drive_cycle(1'b0, 1'b0, 1'b1);
            else if (i == 1) drive_cycle(1'b0, 1'b1);
            else             drive_cycle(1'b1);
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pre_reset[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
        end
        #2 CLK_RES_N = 1'b0;
        #1;
        m_secs = 0; m_state = 0;
        sb.push_back('{16'h0000, 1'b0, 1'b0});
        e = sb.pop_front(); got = dut_obs(); n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %h run=%b wrap=%b, want %h run=%b wrap=%b", got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
        end
        @(negedge CLK_REF);
        CLK_RES_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) drive_cycle(1'b0, 1'b1);
            else        drive_cycle(1'b1);
            e = sb.pop_front(); got = dut_obs(); n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h run=%b wrap=%b, want %h run=%b wrap=%b", i, got.digits, got.running, got.wrap, e.digits, e.running, e.wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_tick_pause();
        test_clear_priority();
        test_adjust();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
